// File: rtl/logic_acc_4b.sv
// logic_acc_4b: flow-controlled accumulator behind the 4-bit gate units.
// Optional parity output is enabled by defining LOGIC_ACC_PARITY_EN.
module logic_acc_4b #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] operand,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] acc,
   output logic             zero,
   output logic             carry,
   output logic [CNT_W-1:0] op_count
`ifdef LOGIC_ACC_PARITY_EN
   ,
   output logic             parity
`endif
);

   localparam logic [2:0] OP_LOAD = 3'd0;
   localparam logic [2:0] OP_AND  = 3'd1;
   localparam logic [2:0] OP_NAND = 3'd2;
   localparam logic [2:0] OP_OR   = 3'd3;
   localparam logic [2:0] OP_NOR  = 3'd4;
   localparam logic [2:0] OP_XOR  = 3'd5;
   localparam logic [2:0] OP_ADD  = 3'd6;
   localparam logic [2:0] OP_CLR  = 3'd7;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nx;
   logic [2:0]       op_q;
   logic [WIDTH-1:0] opnd_q;
   logic [WIDTH-1:0] acc_nx;
   logic             carry_nx;
   logic [WIDTH:0]   sum;
   logic             accept;
   logic             exec;
   logic             done;

   // Handshake decode and next state; the unused encoding behaves as IDLE.
   always_comb begin
      state_nx  = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      accept    = 1'b0;
      exec      = 1'b0;
      done      = 1'b0;
      case (state)
         EXEC: begin
            exec     = 1'b1;
            state_nx = RESP;
         end
         RESP: begin
            out_valid = 1'b1;
            if (out_ready) begin
               done     = 1'b1;
               state_nx = IDLE;
            end
         end
         default: begin
            in_ready = 1'b1;
            if (in_valid) begin
               accept   = 1'b1;
               state_nx = EXEC;
            end
         end
      endcase
   end

   // Result of the latched opcode applied to acc and the latched operand.
   always_comb begin
      sum      = {1'b0, acc} + {1'b0, opnd_q};
      acc_nx   = acc;
      carry_nx = 1'b0;
      case (op_q)
         OP_LOAD: acc_nx = opnd_q;
         OP_AND:  acc_nx = acc & opnd_q;
         OP_NAND: acc_nx = ~(acc & opnd_q);
         OP_OR:   acc_nx = acc | opnd_q;
         OP_NOR:  acc_nx = ~(acc | opnd_q);
         OP_XOR:  acc_nx = acc ^ opnd_q;
         OP_ADD: begin
            acc_nx   = sum[WIDTH-1:0];
            carry_nx = sum[WIDTH];
         end
         OP_CLR:  acc_nx = '0;
         default: acc_nx = acc;
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // Capture opcode and operand only on the accepting edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_q   <= OP_LOAD;
         opnd_q <= '0;
      end else if (accept) begin
         op_q   <= op;
         opnd_q <= operand;
      end
   end

   // Accumulator and flags update once, in EXEC; held through RESP.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc   <= '0;
         zero  <= 1'b1;
         carry <= 1'b0;
      end else if (exec) begin
         acc   <= acc_nx;
         zero  <= (acc_nx == '0);
         carry <= carry_nx;
      end
   end

   // Count completed output handshakes, wrapping naturally.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)       op_count <= '0;
      else if (done) op_count <= op_count + CNT_W'(1);
   end

`ifdef LOGIC_ACC_PARITY_EN
   // Parity of the accumulator, registered alongside it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)       parity <= 1'b0;
      else if (exec) parity <= ^acc_nx;
   end
`endif

endmodule

// File: tb/tb_logic_acc_4b.sv
// tb_logic_acc_4b: vector table, corner sequences and randomized
// operations against a behavioural accumulator model.
module tb_logic_acc_4b;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [2:0] op;
   logic [3:0] operand;
   logic       out_valid;
   logic       out_ready;
   logic [3:0] acc;
   logic       zero;
   logic       carry;
   logic [7:0] op_count;
`ifdef LOGIC_ACC_PARITY_EN
   logic       parity;
`endif

   logic_acc_4b #(.WIDTH(4), .CNT_W(8)) dut (
      .clk(clk),
      .rst(rst),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .op(op),
      .operand(operand),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .acc(acc),
      .zero(zero),
      .carry(carry),
      .op_count(op_count)
`ifdef LOGIC_ACC_PARITY_EN
      ,
      .parity(parity)
`endif
   );

   always #5 clk = ~clk;

   int n_pass = 0;
   int n_total = 0;
   int acc_m = 0;
   int carry_m = 0;
   int cnt_m = 0;

   typedef struct {
      logic [2:0] o;
      logic [3:0] d;
      logic [3:0] ea;
      logic       ez;
      logic       ec;
   } vec_t;

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_total++;
      if (act !== exp)
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      else
         n_pass++;
   endtask

   // Higher-level model: plain integer arithmetic on 4-bit values.
   task automatic model(input int o, input int d);
      int s;
      carry_m = 0;
      case (o)
         0: acc_m = d;
         1: acc_m = acc_m & d;
         2: acc_m = 15 - (acc_m & d);
         3: acc_m = acc_m | d;
         4: acc_m = 15 - (acc_m | d);
         5: acc_m = acc_m ^ d;
         6: begin
            s = acc_m + d;
            carry_m = (s > 15) ? 1 : 0;
            acc_m = s % 16;
         end
         default: acc_m = 0;
      endcase
   endtask

   // One full transaction with optional backpressure and expected result.
   task automatic send(input logic [2:0] o, input logic [3:0] d,
                       input int hold, input logic [3:0] ea,
                       input logic ez, input logic ec);
      @(negedge clk);
      chk("in_ready_idle", 32'(in_ready), 32'(1));
      in_valid  = 1'b1;
      op        = o;
      operand   = d;
      out_ready = (hold == 0);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      op       = 3'($urandom_range(0, 7));
      operand  = 4'($urandom_range(0, 15));
      chk("exec_out_valid", 32'(out_valid), 32'(0));
      chk("exec_in_ready", 32'(in_ready), 32'(0));
      @(posedge clk);
      #1;
      chk("resp_out_valid", 32'(out_valid), 32'(1));
      chk("acc", 32'(acc), 32'(ea));
      chk("zero", 32'(zero), 32'(ez));
      chk("carry", 32'(carry), 32'(ec));
`ifdef LOGIC_ACC_PARITY_EN
      chk("parity", 32'(parity), 32'($countones(ea) % 2));
`endif
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         in_valid = 1'b1;
         op       = 3'($urandom_range(0, 7));
         operand  = 4'($urandom_range(0, 15));
         @(posedge clk);
         #1;
         in_valid = 1'b0;
         chk("bp_out_valid", 32'(out_valid), 32'(1));
         chk("bp_acc", 32'(acc), 32'(ea));
         chk("bp_in_ready", 32'(in_ready), 32'(0));
         chk("bp_count", 32'(op_count), 32'(cnt_m));
      end
      if (hold > 0) begin
         @(negedge clk);
         out_ready = 1'b1;
      end
      @(posedge clk);
      #1;
      cnt_m = (cnt_m + 1) % 256;
      chk("done_out_valid", 32'(out_valid), 32'(0));
      chk("done_in_ready", 32'(in_ready), 32'(1));
      chk("op_count", 32'(op_count), 32'(cnt_m));
   endtask

   task automatic rand_op(input int hold);
      int o;
      int d;
      o = $urandom_range(0, 7);
      d = $urandom_range(0, 15);
      model(o, d);
      send(3'(o), 4'(d), hold, 4'(acc_m), acc_m == 0, carry_m[0]);
   endtask

   vec_t tbl[13];

   initial begin
      tbl[0]  = '{3'd0, 4'b1000, 4'b1000, 1'b0, 1'b0};
      tbl[1]  = '{3'd2, 4'b1001, 4'b0111, 1'b0, 1'b0};
      tbl[2]  = '{3'd0, 4'b1101, 4'b1101, 1'b0, 1'b0};
      tbl[3]  = '{3'd6, 4'b0110, 4'b0011, 1'b0, 1'b1};
      tbl[4]  = '{3'd5, 4'b0011, 4'b0000, 1'b1, 1'b0};
      tbl[5]  = '{3'd3, 4'b0101, 4'b0101, 1'b0, 1'b0};
      tbl[6]  = '{3'd4, 4'b0010, 4'b1000, 1'b0, 1'b0};
      tbl[7]  = '{3'd1, 4'b1100, 4'b1000, 1'b0, 1'b0};
      tbl[8]  = '{3'd7, 4'b0111, 4'b0000, 1'b1, 1'b0};
      tbl[9]  = '{3'd6, 4'b1111, 4'b1111, 1'b0, 1'b0};
      tbl[10] = '{3'd6, 4'b0001, 4'b0000, 1'b1, 1'b1};
      tbl[11] = '{3'd0, 4'b0111, 4'b0111, 1'b0, 1'b0};
      tbl[12] = '{3'd3, 4'b1000, 4'b1111, 1'b0, 1'b0};

      rst       = 1'b1;
      in_valid  = 1'b0;
      op        = 3'd0;
      operand   = 4'd0;
      out_ready = 1'b1;
      #3;
      chk("rst_acc", 32'(acc), 32'(0));
      chk("rst_zero", 32'(zero), 32'(1));
      chk("rst_carry", 32'(carry), 32'(0));
      chk("rst_out_valid", 32'(out_valid), 32'(0));
      chk("rst_count", 32'(op_count), 32'(0));
      chk("rst_in_ready", 32'(in_ready), 32'(1));
`ifdef LOGIC_ACC_PARITY_EN
      chk("rst_parity", 32'(parity), 32'(0));
`endif
      @(negedge clk);
      rst = 1'b0;

      foreach (tbl[i])
         send(tbl[i].o, tbl[i].d, i % 3, tbl[i].ea, tbl[i].ez, tbl[i].ec);
      acc_m = 15;

      // Long backpressure on ADD with stray in_valid pulses.
      model(6, 3);
      send(3'd6, 4'd3, 5, 4'(acc_m), acc_m == 0, carry_m[0]);

      // Reset while holding a result in RESP.
      @(negedge clk);
      in_valid  = 1'b1;
      op        = 3'd0;
      operand   = 4'b1010;
      out_ready = 1'b0;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      chk("pre_rst_acc", 32'(acc), 32'(10));
      chk("pre_rst_valid", 32'(out_valid), 32'(1));
      #2;
      rst = 1'b1;
      #1;
      chk("mid_rst_acc", 32'(acc), 32'(0));
      chk("mid_rst_zero", 32'(zero), 32'(1));
      chk("mid_rst_carry", 32'(carry), 32'(0));
      chk("mid_rst_valid", 32'(out_valid), 32'(0));
      chk("mid_rst_count", 32'(op_count), 32'(0));
      chk("mid_rst_in_ready", 32'(in_ready), 32'(1));
      @(negedge clk);
      rst       = 1'b0;
      out_ready = 1'b1;
      acc_m     = 0;
      carry_m   = 0;
      cnt_m     = 0;

      // Counter wrap after 256 back-to-back LOADs.
      for (int i = 0; i < 256; i++) begin
         model(0, i % 16);
         send(3'd0, 4'(i % 16), 0, 4'(acc_m), acc_m == 0, 1'b0);
      end
      chk("wrap_count", 32'(op_count), 32'(0));

      for (int i = 0; i < 200; i++)
         rand_op($urandom_range(0, 2));

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
